flopoco_fmul: RTL and testbench
===============================

Name: flopoco_fmul

Overview:
- Pipelined floating-point multiplier in FloPoCo format with a 4-bit exponent and a 4-bit fraction: 11-bit words laid out as exn[10:9], sign[8], exp[7:4], frac[3:0].
- Computes R = X*Y with round-to-nearest-even, FloPoCo exception semantics and one cycle of latency.
- Used as the fp multiply core by generated datapaths.

Parameters:
- WE, 4, exponent width (bias = 2^(WE-1)-1 = 7).
- WF, 4, fraction width. Word width = WE+WF+3 = 11.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- X  in  11  operand A, FloPoCo format.
- Y  in  11  operand B, FloPoCo format.
- R  out  11  registered product, FloPoCo format.

Behaviour:
- exn encoding: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Normal value = (-1)^sign * 1.frac * 2^(exp-7). exp 0..15 are all normal codes; there are no subnormals.
- Reset: while reset=0, R=11'b0 (+zero), asynchronously. On release, the first valid R follows the next rising edge.
- Latency: combinational datapath feeding one output register. X,Y sampled at rising edge n appear on R after that edge. Throughput is one product per cycle; no handshake and no enable.
- Sign: sX xor sY for zero, infinity and normal results. NaN results carry sign 0.
- Exception priority:
  - either operand NaN -> NaN;
  - zero*inf -> NaN;
  - either operand inf -> inf;
  - either operand zero -> zero;
  - otherwise normal path.
- For zero, inf and NaN results, exp and frac fields are 0.
- Normal path:
  - Significands sX = {1,fX} and sY = {1,fY} (5 bits each); P = sX*sY (10 bits, range [1,4)).
  - norm = P[9].
  - If norm=1: frac = P[8:5], guard = P[4], sticky = |P[3:0]. Else: frac = P[7:4], guard = P[3], sticky = |P[2:0].
  - Biased exponent E = eX + eY - 7 + norm, computed signed with at least 7 bits.
  - Round bit rnd = guard & (sticky | frac[0]). Add rnd to the concatenation {E, frac}; a fraction carry-out increments E.
  - After rounding: E > 15 -> inf (exn 10). E < 0 -> zero (exn 00, flush). Otherwise exn 01 with exp = E[3:0].
- Reset asserted mid-stream clears R immediately. In-flight products are discarded.

Decomposition:
- Package fmul_pkg holds:
  - WE, WF, BIAS constants;
  - the EXN_ZERO, EXN_NORMAL, EXN_INF, EXN_NAN codes;
  - field-slice helpers.
- One sub-module, fmul_round: takes P, E and norm; produces normalized, rounded exp/frac plus overflow/underflow flags.
- The top level handles exception decode, sign and the output register.

Test Plan:
- X=01_0_1000_0000 (2.0), Y=01_0_1000_1000 (3.0) -> R=01_0_1001_1000 (6.0) one cycle after sampling. Negate X (sign=1) -> R=01_1_1001_1000 (-6.0).
- Tie-to-even round-up: X=01_0_0111_0001 (1.0625), Y=01_0_0111_1000 (1.5) -> R=01_0_0111_1010 (1.625).
- Overflow: X=Y=01_0_1111_0000 -> R=10_0_0000_0000 (+inf).
- Underflow: X=Y=01_0_0000_0000 -> R=00_0_0000_0000.
- Exceptions:
  - X=00_0_0000_0000, Y=10_0_0000_0000 -> R=11_0_0000_0000 (NaN);
  - X=10_1_0000_0000 (-inf), Y=2.0 -> R=10_1_0000_0000 (-inf);
  - NaN*2.0 -> NaN.
- Reset: drive 2.0*3.0 back-to-back, assert reset low between clock edges -> R=0 at once. Deassert -> 6.0 reappears one edge later; back-to-back distinct inputs give one result per cycle.

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared constants and field helpers for the FloPoCo-format multiplier.
// Word layout: exn[WW-1:WW-2], sign, exp[WE-1:0], frac[WF-1:0].
package fmul_pkg;

    localparam int WE   = 4;
    localparam int WF   = 4;
    localparam int WW   = WE + WF + 3;
    localparam int BIAS = (1 << (WE - 1)) - 1;
    // Exponent datapath width: wide enough to hold eX+eY-BIAS+1 plus a rounding carry, signed
    localparam int EW   = WE + 3;

    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    function automatic logic [1:0] get_exn(input logic [WW-1:0] w);
        return w[WW-1:WW-2];
    endfunction

    function automatic logic get_sign(input logic [WW-1:0] w);
        return w[WE+WF];
    endfunction

    function automatic logic [WE-1:0] get_exp(input logic [WW-1:0] w);
        return w[WE+WF-1:WF];
    endfunction

    function automatic logic [WF-1:0] get_frac(input logic [WW-1:0] w);
        return w[WF-1:0];
    endfunction

    function automatic logic [WW-1:0] pack_word(input logic [1:0] exn, input logic sign,
                                                 input logic [WE-1:0] exp, input logic [WF-1:0] frac);
        return {exn, sign, exp, frac};
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalizes the raw significand product, rounds to nearest-even and
// reports exponent overflow/underflow after the rounding carry.
module fmul_round
    import fmul_pkg::*;
(
    input  logic [2*WF+1:0] p,
    input  logic [EW-1:0]   e_pre,
    input  logic            norm,
    output logic [WE-1:0]   exp,
    output logic [WF-1:0]   frac,
    output logic            ovf,
    output logic            unf
);

    logic [WF-1:0]    frac_t;
    logic             guard;
    logic             sticky;
    logic             rnd;
    logic [EW-1:0]    e_n;
    logic [EW+WF-1:0] sum;
    logic [EW-1:0]    e_r;

    always_comb begin
        frac_t = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (norm) begin
            frac_t = p[2*WF:WF+1];
            guard  = p[WF];
            sticky = |p[WF-1:0];
        end else begin
            frac_t = p[2*WF-1:WF];
            guard  = p[WF-1];
            sticky = |p[WF-2:0];
        end
    end

    assign rnd = guard & (sticky | frac_t[0]);
    assign e_n = e_pre + {{(EW-1){1'b0}}, norm};

    // Rounding on the concatenation lets a fraction carry-out bump the exponent for free
    assign sum  = {e_n, frac_t} + {{(EW+WF-1){1'b0}}, rnd};
    assign e_r  = sum[EW+WF-1:WF];
    assign frac = sum[WF-1:0];
    assign exp  = e_r[WE-1:0];

    // e_r is two's complement: sign bit means underflow, any bit above the field means overflow
    assign unf = e_r[EW-1];
    assign ovf = ~e_r[EW-1] & (|e_r[EW-2:WE]);

endmodule

// File: rtl/flopoco_fmul.sv
// FloPoCo floating-point multiplier: exception decode, sign and rounded
// normal-path product registered into R with one cycle of latency.
module flopoco_fmul
    import fmul_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [WW-1:0] X,
    input  logic [WW-1:0] Y,
    output logic [WW-1:0] R
);

    logic [WW-1:0] ops [2];
    logic [1:0]    is_zero;
    logic [1:0]    is_inf;
    logic [1:0]    is_nan;
    logic [WF:0]   sig  [2];
    logic [WE-1:0] expo [2];

    assign ops[0] = X;
    assign ops[1] = Y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign is_zero[gi] = (get_exn(ops[gi]) == EXN_ZERO);
            assign is_inf[gi]  = (get_exn(ops[gi]) == EXN_INF);
            assign is_nan[gi]  = (get_exn(ops[gi]) == EXN_NAN);
            assign sig[gi]     = {1'b1, get_frac(ops[gi])};
            assign expo[gi]    = get_exp(ops[gi]);
        end
    endgenerate

    logic            sign;
    logic [2*WF+1:0] p;
    logic [EW-1:0]   e_pre;
    logic            norm;
    logic [WE-1:0]   exp_rnd;
    logic [WF-1:0]   frac_rnd;
    logic            ovf;
    logic            unf;
    logic [WW-1:0]   r_next;
    logic [WW-1:0]   r_reg;

    assign sign  = get_sign(X) ^ get_sign(Y);
    assign p     = {{(WF+1){1'b0}}, sig[0]} * {{(WF+1){1'b0}}, sig[1]};
    assign norm  = p[2*WF+1];
    assign e_pre = {{(EW-WE){1'b0}}, expo[0]} + {{(EW-WE){1'b0}}, expo[1]} - EW'(BIAS);

    fmul_round u_round (
        .p     (p),
        .e_pre (e_pre),
        .norm  (norm),
        .exp   (exp_rnd),
        .frac  (frac_rnd),
        .ovf   (ovf),
        .unf   (unf)
    );

    always_comb begin
        r_next = '0;
        if (|is_nan || (is_zero[0] && is_inf[1]) || (is_inf[0] && is_zero[1])) begin
            r_next = pack_word(EXN_NAN, 1'b0, '0, '0);
        end else if (|is_inf) begin
            r_next = pack_word(EXN_INF, sign, '0, '0);
        end else if (|is_zero) begin
            r_next = pack_word(EXN_ZERO, sign, '0, '0);
        end else if (ovf) begin
            r_next = pack_word(EXN_INF, sign, '0, '0);
        end else if (unf) begin
            r_next = pack_word(EXN_ZERO, sign, '0, '0);
        end else begin
            r_next = pack_word(EXN_NORMAL, sign, exp_rnd, frac_rnd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg <= '0;
        end else begin
            r_reg <= r_next;
        end
    end

    assign R = r_reg;

endmodule

// File: tb/tb_flopoco_fmul.sv
// Scoreboard bench for flopoco_fmul: stimulus pushes expected words,
// an independent monitor pops and compares one cycle after sampling.
module tb_flopoco_fmul;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] X = '0;
    logic [10:0] Y = '0;
    logic [10:0] R;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q [$];
    string       name_q [$];
    logic [10:0] opa_q [$];
    logic [10:0] opb_q [$];

    always #5 clk = ~clk;

    flopoco_fmul dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y),
        .R     (R)
    );

    localparam logic [10:0] TWO   = 11'b01_0_1000_0000;
    localparam logic [10:0] THREE = 11'b01_0_1000_1000;
    localparam logic [10:0] SIX   = 11'b01_0_1001_1000;
    localparam logic [10:0] NAN_W = 11'b11_0_0000_0000;

    // Reference: exact integer product of the two significands, rounded to a
    // 5-bit significand by remainder comparison, then range-checked.
    function automatic logic [10:0] ref_mul(input logic [10:0] a, input logic [10:0] b);
        int m, sh, q, rem, half, e, f;
        logic s;
        logic [1:0] xa, xb;
        logic [3:0] ef, ff;
        xa = a[10:9];
        xb = b[10:9];
        s  = a[8] ^ b[8];
        if (xa == 2'b11 || xb == 2'b11) return 11'b11_0_0000_0000;
        if ((xa == 2'b00 && xb == 2'b10) || (xa == 2'b10 && xb == 2'b00)) return 11'b11_0_0000_0000;
        if (xa == 2'b10 || xb == 2'b10) return {2'b10, s, 8'b0};
        if (xa == 2'b00 || xb == 2'b00) return {2'b00, s, 8'b0};
        m    = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        sh   = (m >= 512) ? 5 : 4;
        q    = m >> sh;
        rem  = m - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        e = int'(a[7:4]) + int'(b[7:4]) - 7 + (sh - 4);
        if (q == 32) begin
            q = 16;
            e = e + 1;
        end
        if (e > 15) return {2'b10, s, 8'b0};
        if (e < 0) return {2'b00, s, 8'b0};
        f  = q - 16;
        ef = e[3:0];
        ff = f[3:0];
        return {2'b01, s, ef, ff};
    endfunction

    task automatic issue(input logic [10:0] a, input logic [10:0] b,
                         input logic [10:0] expv, input string nm);
        @(negedge clk);
        X = a;
        Y = b;
        exp_q.push_back(expv);
        name_q.push_back(nm);
        opa_q.push_back(a);
        opb_q.push_back(b);
    endtask

    task automatic check_now(input logic [10:0] expv, input string nm);
        checks++;
        if (R !== expv) begin
            errors++;
            $display("FAIL %s R=%b required=%b", nm, R, expv);
        end else begin
            $display("ok   %s R=%b", nm, R);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && exp_q.size() > 0) begin
            logic [10:0] e, a, b;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = opa_q.pop_front();
            b  = opb_q.pop_front();
            checks++;
            if (R !== e) begin
                errors++;
                $display("FAIL %s X=%b Y=%b R=%b required=%b", nm, a, b, R, e);
            end else begin
                $display("ok   %s X=%b Y=%b R=%b", nm, a, b, R);
            end
        end
    end

    initial begin
        int n;
        logic [10:0] a, b;

        X = TWO;
        Y = THREE;
        #2;
        check_now(11'b0, "reset_state");
        @(negedge clk);
        check_now(11'b0, "reset_held");
        reset = 1'b1;

        issue(TWO, THREE, SIX, "two_times_three");
        issue(11'b01_1_1000_0000, THREE, 11'b01_1_1001_1000, "neg_two_times_three");
        issue(11'b01_0_0111_0001, 11'b01_0_0111_1000, 11'b01_0_0111_1010, "tie_even_up");
        issue(11'b01_0_1111_0000, 11'b01_0_1111_0000, 11'b10_0_0000_0000, "overflow");
        issue(11'b01_0_0000_0000, 11'b01_0_0000_0000, 11'b00_0_0000_0000, "underflow");
        issue(11'b00_0_0000_0000, 11'b10_0_0000_0000, NAN_W, "zero_times_inf");
        issue(11'b10_1_0000_0000, TWO, 11'b10_1_0000_0000, "neg_inf_times_two");
        issue(11'b11_1_0000_0000, TWO, NAN_W, "nan_times_two");
        issue(11'b00_1_0000_0000, THREE, 11'b00_1_0000_0000, "neg_zero_times_three");
        issue(11'b01_0_0111_1111, 11'b01_0_0111_1111, ref_mul(11'b01_0_0111_1111, 11'b01_0_0111_1111), "max_frac_square");

        // Asynchronous reset in mid-cycle after back-to-back products
        issue(TWO, THREE, SIX, "pre_reset_a");
        issue(TWO, THREE, SIX, "pre_reset_b");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_now(11'b0, "reset_async_clear");
        @(negedge clk);
        X = THREE;
        Y = THREE;
        @(posedge clk);
        #1;
        check_now(11'b0, "reset_discard_inflight");
        @(negedge clk);
        reset = 1'b1;
        X = TWO;
        Y = THREE;
        exp_q.push_back(SIX);
        name_q.push_back("post_reset_first");
        opa_q.push_back(TWO);
        opb_q.push_back(THREE);
        issue(THREE, THREE, 11'b01_0_1010_0010, "post_reset_b2b_nine");
        issue(TWO, TWO, 11'b01_0_1001_0000, "post_reset_b2b_four");

        for (int i = 0; i < 300; i++) begin
            a = 11'($urandom);
            b = 11'($urandom);
            if ($urandom_range(0, 9) < 7) a[10:9] = 2'b01;
            if ($urandom_range(0, 9) < 7) b[10:9] = 2'b01;
            issue(a, b, ref_mul(a, b), "random");
        end

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
